mc_maindec: RTL and testbench

//   Multicycle main control FSM. Decodes the instruction opcode into per-cycle datapath controls.

---
 rtl/mc_maindec.sv | 143 ++++++++++++++
 tb/tb_mc_maindec.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: decodes the opcode into per-cycle datapath controls.
// Moore outputs are registered from the next state; only memready gating and illegal are combinational.
module mc_maindec #(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic [3:0] state,
  output logic       memwrite,
  output logic       lord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       branch,
  output logic       pcwrite,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       memwrite;
    logic       lord;
    logic       fetch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_mr;
  logic   w_op_legal;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.alusrcb = 2'b01; c.fetch = 1'b1; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.lord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.lord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQ:     begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = 2'b10; c.jump = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_mr       = WAIT_MEM ? memready : 1'b1;
  assign w_op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = w_mr ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BEQ;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   w_next = w_mr ? MEMWB : MEMRD;
      MEMWR:   w_next = w_mr ? FETCH : MEMWR;
      EXECUTE: w_next = ALUWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  // Control word is decoded from the next state so it lines up with r_state after the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_ctrl  <= ctrl_of(FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
    end
  end

  assign state    = r_state;
  assign memwrite = r_ctrl.memwrite;
  assign lord     = r_ctrl.lord;
  assign irwrite  = r_ctrl.fetch & w_mr;
  assign regdst   = r_ctrl.regdst;
  assign memtoreg = r_ctrl.memtoreg;
  assign regwrite = r_ctrl.regwrite;
  assign alusrca  = r_ctrl.alusrca;
  assign alusrcb  = r_ctrl.alusrcb;
  assign pcsrc    = r_ctrl.pcsrc;
  assign aluop    = r_ctrl.aluop;
  assign branch   = r_ctrl.branch;
  assign pcwrite  = (r_ctrl.fetch & w_mr) | r_ctrl.jump;
  assign illegal  = (r_state == DECODE) && !w_op_legal;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed self-checking bench for mc_maindec: one DUT honouring memready stalls, one ignoring them.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memready;

  logic [3:0] state, n_state;
  logic       memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca, branch, pcwrite, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       n_memwrite, n_lord, n_irwrite, n_regdst, n_memtoreg, n_regwrite, n_alusrca;
  logic       n_branch, n_pcwrite, n_illegal;
  logic [1:0] n_alusrcb, n_pcsrc, n_aluop;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_maindec #(.WAIT_MEM(1'b1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready), .state(state),
    .memwrite(memwrite), .lord(lord), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .branch(branch), .pcwrite(pcwrite), .illegal(illegal)
  );

  mc_maindec #(.WAIT_MEM(1'b0)) u_nw (
    .clk(clk), .reset(reset), .op(op), .memready(memready), .state(n_state),
    .memwrite(n_memwrite), .lord(n_lord), .irwrite(n_irwrite), .regdst(n_regdst),
    .memtoreg(n_memtoreg), .regwrite(n_regwrite), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .pcsrc(n_pcsrc), .aluop(n_aluop), .branch(n_branch), .pcwrite(n_pcwrite), .illegal(n_illegal)
  );

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    memready = 1'b1;
    op = 6'b100011;
    reset = 1'b1;
    #2;
    n_tests++;
    if (state !== 4'd0 || alusrcb !== 2'b01 || aluop !== 2'b00 || pcsrc !== 2'b00 ||
        irwrite !== 1'b1 || pcwrite !== 1'b1 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%0d srcb=%b aluop=%b pcsrc=%b irw=%b pcw=%b rw=%b mw=%b, want st=0 srcb=01 aluop=00 pcsrc=00 irw=1 pcw=1 rw=0 mw=0",
               state, alusrcb, aluop, pcsrc, irwrite, pcwrite, regwrite, memwrite);
    end
    memready = 1'b0;
    #1;
    n_tests++;
    if (irwrite !== 1'b0 || pcwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gated: got irw=%b pcw=%b, want 0 0", irwrite, pcwrite);
    end
    memready = 1'b1;
    do_reset();
  endtask

  task automatic test_lw();
    logic [3:0] seq [6];
    logic       rw  [6];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    rw  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 6'b100011;
    memready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (state !== seq[i] || regwrite !== rw[i] || memtoreg !== rw[i]) begin
        n_fail++;
        $display("FAIL lw_cycle%0d: got st=%0d rw=%b m2r=%b, want st=%0d rw=%b m2r=%b",
                 i, state, regwrite, memtoreg, seq[i], rw[i], rw[i]);
      end
      if (i == 1) begin
        n_tests++;
        if (alusrcb !== 2'b11 || illegal !== 1'b0) begin
          n_fail++;
          $display("FAIL lw_decode: got srcb=%b ill=%b, want 11 0", alusrcb, illegal);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (lord !== 1'b1 || memwrite !== 1'b0) begin
          n_fail++;
          $display("FAIL lw_memrd: got lord=%b mw=%b, want 1 0", lord, memwrite);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_rtype();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    op = 6'b000000;
    memready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (state !== seq[i]) begin
        n_fail++;
        $display("FAIL rtype_state%0d: got %0d want %0d", i, state, seq[i]);
      end
      if (i == 2) begin
        n_tests++;
        if (aluop !== 2'b10 || alusrca !== 1'b1 || alusrcb !== 2'b00 || regwrite !== 1'b0) begin
          n_fail++;
          $display("FAIL rtype_exec: got aluop=%b srca=%b srcb=%b rw=%b, want 10 1 00 0",
                   aluop, alusrca, alusrcb, regwrite);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (regdst !== 1'b1 || regwrite !== 1'b1 || memtoreg !== 1'b0) begin
          n_fail++;
          $display("FAIL rtype_wb: got rd=%b rw=%b m2r=%b, want 1 1 0", regdst, regwrite, memtoreg);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_beq();
    logic [3:0] seq [4];
    seq = '{4'd0, 4'd1, 4'd8, 4'd0};
    op = 6'b000100;
    memready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (state !== seq[i]) begin
        n_fail++;
        $display("FAIL beq_state%0d: got %0d want %0d", i, state, seq[i]);
      end
      if (i == 2) begin
        n_tests++;
        if (aluop !== 2'b01 || pcsrc !== 2'b01 || branch !== 1'b1 || pcwrite !== 1'b0 || alusrca !== 1'b1) begin
          n_fail++;
          $display("FAIL beq_ctrl: got aluop=%b pcsrc=%b br=%b pcw=%b srca=%b, want 01 01 1 0 1",
                   aluop, pcsrc, branch, pcwrite, alusrca);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_jump();
    op = 6'b000010;
    memready = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    n_tests++;
    if (state !== 4'd11 || pcsrc !== 2'b10 || pcwrite !== 1'b1 || branch !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_ctrl: got st=%0d pcsrc=%b pcw=%b br=%b, want 11 10 1 0", state, pcsrc, pcwrite, branch);
    end
    next_cycle();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL jump_return: got %0d want 0", state);
    end
  endtask

  task automatic test_sw_stall();
    op = 6'b101011;
    memready = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      memready = (i == 3);
      #1;
      n_tests++;
      if (state !== 4'd5 || memwrite !== 1'b1 || lord !== 1'b1) begin
        n_fail++;
        $display("FAIL sw_hold%0d: got st=%0d mw=%b lord=%b, want 5 1 1", i, state, memwrite, lord);
      end
      next_cycle();
    end
    n_tests++;
    if (state !== 4'd0 || memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_done: got st=%0d mw=%b, want 0 0", state, memwrite);
    end
  endtask

  task automatic test_fetch_stall();
    logic [3:0] nseq [6];
    nseq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = 6'b100011;
    memready = 1'b1;
    do_reset();
    memready = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (state !== 4'd0 || irwrite !== 1'b0 || pcwrite !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_stall%0d: got st=%0d irw=%b pcw=%b, want 0 0 0", i, state, irwrite, pcwrite);
      end
      n_tests++;
      if (n_state !== nseq[i]) begin
        n_fail++;
        $display("FAIL nowait_state%0d: got %0d want %0d", i, n_state, nseq[i]);
      end
      if (i == 0) begin
        n_tests++;
        if (n_irwrite !== 1'b1 || n_pcwrite !== 1'b1) begin
          n_fail++;
          $display("FAIL nowait_fetch: got irw=%b pcw=%b, want 1 1", n_irwrite, n_pcwrite);
        end
      end
      next_cycle();
    end
    memready = 1'b1;
    next_cycle();
    n_tests++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL fetch_release: got %0d want 1", state);
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    memready = 1'b1;
    do_reset();
    next_cycle();
    n_tests++;
    if (state !== 4'd1 || illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_decode: got st=%0d ill=%b, want 1 1", state, illegal);
    end
    next_cycle();
    n_tests++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_return: got st=%0d ill=%b, want 0 0", state, illegal);
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011;
    memready = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    next_cycle();
    memready = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd3) begin
      n_fail++;
      $display("FAIL mid_setup: got %0d want 3", state);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0 || lord !== 1'b0 || regwrite !== 1'b0 || memwrite !== 1'b0 || irwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got st=%0d lord=%b rw=%b mw=%b irw=%b, want 0 0 0 0 0",
               state, lord, regwrite, memwrite, irwrite);
    end
    next_cycle();
    reset = 1'b0;
    memready = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0 || regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: got st=%0d rw=%b, want 0 0", state, regwrite);
    end
  endtask

  initial begin
    reset = 1'b1;
    op = '0;
    memready = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jump();
    test_sw_stall();
    test_fetch_stall();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
